priority_coder_iter: RTL and testbench
======================================

Name: priority_coder_iter

Overview:
Parametrised sequential successor to the combinational 16-bit priority coder. Accepts a WIDTH-bit word over a valid/ready handshake and emits the position of every set bit, one per cycle, in LSB-first or MSB-first order, with a last-beat marker. An all-zero word produces an explicit "none" beat, so it is never confused with a hit at position 0. Used wherever downstream logic must service every requester in a mask rather than only the winner.

Parameters:
WIDTH, 16, input word width; legal range 2..256.
MSB_FIRST, 0, scan order: 0 = lowest set bit first, matching the existing coder; 1 = highest set bit first.
POS_W, $clog2(WIDTH), localparam; width of position outputs.

Ports:
clk  in  1  clock; all state is updated on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a word; 1 only in IDLE.
in_data  in  WIDTH  mask to scan.
out_valid  out  1  out_pos, out_idx, out_last and out_none are valid.
out_ready  in  1  downstream accepts the current beat.
out_pos  out  POS_W  bit position of the current hit.
out_idx  out  POS_W+1  ordinal of the beat within the word, starting at 0.
out_last  out  1  current beat is the final beat for this word.
out_none  out  1  word was all zero; out_pos is 0.

Behaviour:
- Reset (async assert, sync release): state = IDLE; residual mask = 0; out_idx = 0; out_valid = 0, out_pos = 0, out_last = 0, out_none = 0; in_ready = 1 once rst deasserts.
- States: IDLE, SCAN.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: load residual <= in_data, out_idx <= 0, zero flag <= (in_data == 0); go to SCAN.
- SCAN:
  - in_ready = 0, out_valid = 1.
  - out_pos = encode(residual): lowest set bit if MSB_FIRST = 0, highest set bit if MSB_FIRST = 1.
  - out_last = 1 when residual has at most one set bit (popcount <= 1).
  - out_none = zero flag.
- Beat acceptance (out_valid && out_ready):
  - clear bit out_pos in residual;
  - out_idx increments;
  - if out_last, return to IDLE.
- Zero word: exactly one beat with out_none = 1, out_pos = 0, out_last = 1, out_idx = 0.
- Latency: word accepted at edge N gives first out_valid in the cycle after edge N. Throughput is 1 beat per cycle while out_ready = 1.
- A word with k set bits (k >= 1) produces exactly k beats; out_idx runs 0..k-1.
- Backpressure: while out_valid && !out_ready, all out_* are held stable and residual is unchanged.
- No overlap: a new word is accepted only in IDLE, so the next word is taken at the earliest one cycle after the last beat is accepted. in_data is ignored outside IDLE.
- Full word (all ones): WIDTH beats; the final beat has out_pos = WIDTH-1 (LSB-first) or 0 (MSB-first).
- Reset mid-SCAN: residual is discarded immediately, out_valid drops asynchronously, and no further beats of that word are emitted.
- All outputs are a function of registered state only; there is no combinational path from in_* to out_*. out_ready only gates the state update.

Decomposition:
- Package priority_coder_pkg:
  - state enum {IDLE, SCAN};
  - function clog2_safe(n), returning at least 1;
  - constants ORDER_LSB = 0 and ORDER_MSB = 1.
- Sub-module priority_coder_find (combinational, parameters WIDTH and MSB_FIRST):
  - inputs: mask;
  - outputs: pos, found, single (popcount <= 1).
  - Instantiated once on the residual register.
- Top level: FSM, residual register, out_idx counter, zero flag.

Test Plan:
- Reset, then in_data = 16'h0000 with out_ready = 1 -> one beat: out_none = 1, out_pos = 0, out_last = 1, out_idx = 0; in_ready returns to 1 the next cycle.
- MSB_FIRST = 0, in_data = 16'b1010_0011_0000_0100, out_ready = 1 -> out_pos sequence 2, 8, 9, 13, 15 on consecutive cycles; out_idx 0..4; out_last only on 15.
- Same word with MSB_FIRST = 1 -> sequence 15, 13, 9, 8, 2; single-bit words 16'h8000 and 16'h0001 each give one beat at 15 and 0 respectively.
- in_data = 16'hFFFF, out_ready low on every other cycle -> 16 beats, positions 0..15; outputs held stable during every stalled cycle; in_ready = 0 throughout.
- Reset asserted on the third beat of 16'b0000_1111_0000_0000 -> out_valid = 0 immediately; after release in_ready = 1, and the next word 16'h0020 yields a single beat at 5 with out_idx = 0.
- WIDTH = 32, in_data = 32'h8000_0001 -> beats at 0 then 31; WIDTH = 4, in_data = 4'b0110 -> beats at 1 then 2.

Source files
------------

// File: rtl/priority_coder_pkg.sv
// Shared types and helpers for the iterating priority coder and its bit finder.
package priority_coder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int ORDER_LSB = 0;
  localparam int ORDER_MSB = 1;

  // Position width for an n-bit word; never 0, so a 1-bit position bus still exists.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_coder_iter_if.sv
// Word-in / beat-out handshake bundle for priority_coder_iter.
interface priority_coder_iter_if #(
  parameter int WIDTH = 16
);
  import priority_coder_pkg::*;

  localparam int POS_W = clog2_safe(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic [POS_W:0]   out_idx;
  logic             out_last;
  logic             out_none;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_pos, out_idx, out_last, out_none
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_pos, out_idx, out_last, out_none
  );

endinterface

// File: rtl/priority_coder_find.sv
// Combinational scan of a mask: first set bit in the configured order, plus
// flags for "any bit set" and "at most one bit set".
module priority_coder_find
  import priority_coder_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MSB_FIRST = ORDER_LSB,
  localparam int POS_W     = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [POS_W-1:0] pos,
  output logic             found,
  output logic             single
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    pos = '0;
    if (MSB_FIRST == ORDER_MSB) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mask[i]) pos = POS_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask[i]) pos = POS_W'(i);
      end
    end
  end

  assign found  = |mask;
  // Clearing the lowest set bit leaves zero exactly when popcount <= 1.
  assign single = ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_coder_iter.sv
// Accepts a mask word and emits the position of every set bit, one beat per
// cycle; an all-zero word yields a single "none" beat.
module priority_coder_iter
  import priority_coder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = ORDER_LSB
) (
  input logic                  clk,
  input logic                  rst,
  priority_coder_iter_if.slave bus
);

  localparam int POS_W = clog2_safe(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] residual;
  logic [WIDTH-1:0] hit_onehot;
  logic [POS_W:0]   idx;
  logic             zero_flag;

  logic [POS_W-1:0] hit_pos;
  logic             hit_found;
  logic             hit_single;

  logic in_ready, out_valid, in_fire, out_fire;

  priority_coder_find #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_find (
    .mask   (residual),
    .pos    (hit_pos),
    .found  (hit_found),
    .single (hit_single)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = SCAN;
      end
      SCAN: begin
        out_valid = 1'b1;
        if (bus.out_ready && hit_single) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_fire    = in_ready && bus.in_valid;
  assign out_fire   = out_valid && bus.out_ready;
  assign hit_onehot = WIDTH'(1) << hit_pos;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residual  <= '0;
      idx       <= '0;
      zero_flag <= 1'b0;
    end else if (in_fire) begin
      residual  <= bus.in_data;
      idx       <= '0;
      zero_flag <= (bus.in_data == '0);
    end else if (out_fire) begin
      residual <= residual & ~hit_onehot;
      idx      <= idx + 1'b1;
    end
  end

  // Outputs depend on registered state only; an empty residual reports position 0.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pos   = (out_valid && hit_found) ? hit_pos : '0;
  assign bus.out_idx   = idx;
  assign bus.out_last  = out_valid && hit_single;
  assign bus.out_none  = out_valid && zero_flag;

endmodule

// File: tb/tb_priority_coder_iter.sv
// Bench for priority_coder_iter: four configurations, compared every cycle
// against a list-of-hits model, plus literal beat sequences for known words.
module tb_priority_coder_iter;
  import priority_coder_pkg::*;

  localparam int N    = 4;
  localparam int MAXW = 32;
  localparam int CW [N] = '{16, 16, 32, 4};
  localparam int CM [N] = '{ORDER_LSB, ORDER_MSB, ORDER_LSB, ORDER_LSB};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]           in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [N-1:0]           out_last_v, out_none_v;
  logic [N-1:0][MAXW-1:0] in_data_v;
  logic [N-1:0][8:0]      out_pos_v, out_idx_v;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = CW[g];
    priority_coder_iter_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid_v[g];
    assign bus.in_data   = in_data_v[g][W-1:0];
    assign bus.out_ready = out_ready_v[g];
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign out_pos_v[g]   = 9'(bus.out_pos);
    assign out_idx_v[g]   = 9'(bus.out_idx);
    assign out_last_v[g]  = bus.out_last;
    assign out_none_v[g]  = bus.out_none;
    priority_coder_iter #(.WIDTH(W), .MSB_FIRST(CM[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct {
    int pos;
    int idx;
    bit last;
    bit none;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  int          cyc      = 0;
  int          ready_mode = 0;  // 0: always ready, 1: every other cycle, 2: random
  bit          have_word  = 1'b0;
  logic [31:0] word       = '0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (config %0d, t=%0t)", name, got, exp, cur, $time);
    end
  endtask

  // Every beat a word must produce: its set bits in scan order, or one "none" beat.
  function automatic void expand(input logic [31:0] w, input int width, input int order);
    int    hits[$];
    beat_t b;
    for (int i = 0; i < width; i++) begin
      if (w[i]) begin
        if (order == ORDER_MSB) hits.push_front(i);
        else                    hits.push_back(i);
      end
    end
    if (hits.size() == 0) begin
      b = '{pos: 0, idx: 0, last: 1'b1, none: 1'b1};
      exp_q.push_back(b);
    end else begin
      foreach (hits[k]) begin
        b = '{pos: hits[k], idx: k, last: (k == hits.size() - 1), none: 1'b0};
        exp_q.push_back(b);
      end
    end
  endfunction

  // One cycle: compare the active configuration at the falling edge, drive
  // the inputs for the next rising edge, then advance the model.
  task automatic tick();
    bit    busy;
    bit    r;
    beat_t seen;
    @(negedge clk);
    busy = (exp_q.size() != 0);
    if (!rst) begin
      check("in_ready", int'(in_ready_v[cur]), int'(!busy));
      check("out_valid", int'(out_valid_v[cur]), int'(busy));
      if (busy) begin
        check("out_pos", int'(out_pos_v[cur]), exp_q[0].pos);
        check("out_idx", int'(out_idx_v[cur]), exp_q[0].idx);
        check("out_last", int'(out_last_v[cur]), int'(exp_q[0].last));
        check("out_none", int'(out_none_v[cur]), int'(exp_q[0].none));
      end else begin
        check("out_last_idle", int'(out_last_v[cur]), 0);
        check("out_none_idle", int'(out_none_v[cur]), 0);
      end
    end
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = (cyc % 2) == 1;
      default: r = 1'($urandom_range(0, 1));
    endcase
    cyc++;
    out_ready_v      = '1;
    out_ready_v[cur] = r;
    in_valid_v       = '0;
    in_valid_v[cur]  = have_word;
    in_data_v[cur]   = have_word ? word : $urandom;
    if (!rst) begin
      if (busy) begin
        if (r) begin
          seen = '{pos: int'(out_pos_v[cur]), idx: int'(out_idx_v[cur]),
                   last: out_last_v[cur], none: out_none_v[cur]};
          got_q.push_back(seen);
          void'(exp_q.pop_front());
        end
      end else if (have_word) begin
        expand(word, CW[cur], CM[cur]);
        have_word = 1'b0;
      end
    end
  endtask

  task automatic run_word(input logic [31:0] w);
    int n;
    if (ready_mode == 2) repeat ($urandom_range(0, 2)) tick();
    word      = w;
    have_word = 1'b1;
    got_q.delete();
    n = 0;
    do begin
      tick();
      n++;
    end while ((have_word || exp_q.size() != 0) && n < 400);
    check("word_drained", int'(have_word || exp_q.size() != 0), 0);
    tick();
  endtask

  task automatic expect_seq(input string name, input int exp[$]);
    check({name, "_beats"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      check({name, "_pos"}, got_q[i].pos, exp[i]);
    end
  endtask

  function automatic logic [31:0] rand_word(input int width);
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0:       w = '0;
      1:       w = 32'(1) << $urandom_range(0, width - 1);
      2:       w = $urandom;
      default: w = $urandom & $urandom;
    endcase
    return w;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s[$];
    rst         = 1'b1;
    in_valid_v  = '0;
    in_data_v   = '0;
    out_ready_v = '1;
    #12;
    check("rst_out_valid", int'(out_valid_v), 0);
    check("rst_out_pos", int'(out_pos_v[0]), 0);
    check("rst_out_idx", int'(out_idx_v[0]), 0);
    check("rst_out_last", int'(out_last_v), 0);
    check("rst_out_none", int'(out_none_v), 0);
    #10 rst = 1'b0;
    #1  check("post_rst_in_ready", int'(in_ready_v), 15);

    // 16-bit, LSB first
    cur = 0;
    run_word(32'h0000);
    s = '{0};
    expect_seq("zero_word", s);
    if (got_q.size() == 1) begin
      check("zero_word_none", int'(got_q[0].none), 1);
      check("zero_word_last", int'(got_q[0].last), 1);
      check("zero_word_idx", got_q[0].idx, 0);
    end
    run_word(32'hA304);
    s = '{2, 8, 9, 13, 15};
    expect_seq("lsb_a304", s);
    ready_mode = 1;
    run_word(32'hFFFF);
    s.delete();
    for (int i = 0; i < 16; i++) s.push_back(i);
    expect_seq("lsb_ffff_stall", s);
    ready_mode = 0;

    // Reset in the middle of a word, while its third beat is on the outputs
    word      = 32'h0F00;
    have_word = 1'b1;
    for (int n = 0; n < 20 && !(exp_q.size() > 0 && exp_q[0].idx == 2); n++) tick();
    @(posedge clk);
    #2;
    check("pre_rst_idx", int'(out_idx_v[0]), 2);
    check("pre_rst_pos", int'(out_pos_v[0]), 10);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid_v[0]), 0);
    exp_q.delete();
    have_word = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("mid_rst_in_ready", int'(in_ready_v[0]), 1);
    run_word(32'h0020);
    s = '{5};
    expect_seq("after_rst", s);
    if (got_q.size() == 1) check("after_rst_idx", got_q[0].idx, 0);

    // 16-bit, MSB first
    cur = 1;
    run_word(32'hA304);
    s = '{15, 13, 9, 8, 2};
    expect_seq("msb_a304", s);
    run_word(32'h8000);
    s = '{15};
    expect_seq("msb_8000", s);
    run_word(32'h0001);
    s = '{0};
    expect_seq("msb_0001", s);
    run_word(32'hFFFF);
    s.delete();
    for (int i = 15; i >= 0; i--) s.push_back(i);
    expect_seq("msb_ffff", s);

    // 32-bit and 4-bit, LSB first
    cur = 2;
    run_word(32'h8000_0001);
    s = '{0, 31};
    expect_seq("w32_ends", s);
    cur = 3;
    run_word(32'h0000_0006);
    s = '{1, 2};
    expect_seq("w4_0110", s);

    // Random words, random backpressure and idle gaps, on every configuration
    ready_mode = 2;
    for (int c = 0; c < N; c++) begin
      cur = c;
      for (int k = 0; k < 40; k++) run_word(rand_word(CW[c]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
